// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: tap table, lock window, receiver FSM states, config-word layout.
// Polynomial x^L + ... + x^k + 1 means b[n] = XOR of b[n-k]; LFSR state bit k-1 holds b[n-k].
package prbs_pkg;

   localparam int LFSR_MAX   = 10;
   localparam int WIN_LEN    = 64;
   localparam int ERR_THRESH = 8;

   localparam int CFG_DIV_LSB   = 0;
   localparam int CFG_ORDER_LSB = 11;
   localparam int CFG_EN_BIT    = 14;
   localparam int CFG_CLR_BIT   = 15;
   localparam int CFG_PHASE_LSB = 16;

   localparam int REC_BIT_POS  = 24;
   localparam int REC_ERR_POS  = 25;
   localparam int REC_LOCK_POS = 26;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SKIP,
      ST_SEED,
      ST_CHECK
   } rx_state_t;

   function automatic logic [LFSR_MAX-1:0] tap_mask(input logic [2:0] order);
      case (order)
         3'd0:    tap_mask = 10'h006;   // x3+x2+1
         3'd1:    tap_mask = 10'h00C;   // x4+x3+1
         3'd2:    tap_mask = 10'h014;   // x5+x3+1
         3'd3:    tap_mask = 10'h030;   // x6+x5+1
         3'd4:    tap_mask = 10'h060;   // x7+x6+1
         3'd5:    tap_mask = 10'h0B8;   // x8+x6+x5+x4+1
         3'd6:    tap_mask = 10'h110;   // x9+x5+1
         default: tap_mask = 10'h240;   // x10+x7+1
      endcase
   endfunction

endpackage

// File: rtl/prbs_rx_lfsr.sv
// Loadable receive LFSR: shifts decided bits in at bit 0, exposes the predicted next bit.
// Latency 0 for exp_bit (combinational from state); no backpressure.
module prbs_rx_lfsr
   import prbs_pkg::*;
(
   input  logic                aclk,
   input  logic                srst,
   input  logic                clr,
   input  logic                shift,
   input  logic                din,
   input  logic [LFSR_MAX-1:0] tap_mask,
   output logic                exp_bit
);

   logic [LFSR_MAX-1:0] sr;

   always_ff @(posedge aclk) begin
      if (srst || clr) begin
         sr <= '0;
      end else if (shift) begin
         sr <= {sr[LFSR_MAX-2:0], din};
      end
   end

   assign exp_bit = ^(sr & tap_mask);

endmodule

// File: rtl/axis_red_pitaya_prbs_rx.sv
// PRBS receiver: slices ADC lane A into chips, self-syncs an LFSR, counts errors; PRBS_RX_INTEGRATE_EN selects integrate-and-dump.
// Latency: record 2 cycles after a chip's last sample. Never stalls: tready=1, records dropped (sticky ovf) if sink not ready.
module axis_red_pitaya_prbs_rx
   import prbs_pkg::*;
#(
   parameter int ADC_DATA_WIDTH   = 14,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int ACC_WIDTH        = 24
) (
   input  logic                        aclk,
   input  logic                        srst,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic [31:0]                 rx_cfg_i,
   output logic [31:0]                 m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        rx_lock_o,
   output logic [31:0]                 rx_err_cnt_o,
   output logic [31:0]                 rx_chip_cnt_o,
   output logic                        rx_ovf_o
);

   rx_state_t            state, state_nxt;
   logic [7:0]           cfg_div, cfg_phase, div_q, div_eff, samp_cnt, skip_cnt;
   logic [2:0]           cfg_order, order_q;
   logic                 cfg_en, cfg_clr;
   logic [ACC_WIDTH-1:0] sample_ext, acc;
   logic                 in_chip, take, skip, chip_last, chip_end_q;
   logic                 dec_bit, exp_bit, seeding, checking, err;
   logic                 seed_last, win_end, lock_lost, lock_nxt;
   logic [3:0]           seed_cnt;
   logic [5:0]           win_cnt;
   logic [6:0]           win_err, win_errs;
   logic [31:0]          rec;
   logic                 unused_bits;

   assign s_axis_tready = 1'b1;
   assign cfg_div       = rx_cfg_i[CFG_DIV_LSB +: 8];
   assign cfg_order     = rx_cfg_i[CFG_ORDER_LSB +: 3];
   assign cfg_en        = rx_cfg_i[CFG_EN_BIT];
   assign cfg_clr       = rx_cfg_i[CFG_CLR_BIT];
   assign cfg_phase     = rx_cfg_i[CFG_PHASE_LSB +: 8];
   assign sample_ext    = {{(ACC_WIDTH-ADC_DATA_WIDTH){s_axis_tdata[ADC_DATA_WIDTH-1]}},
                           s_axis_tdata[ADC_DATA_WIDTH-1:0]};
   assign unused_bits   = ^{s_axis_tdata[AXIS_TDATA_WIDTH-1:ADC_DATA_WIDTH], rx_cfg_i[10:8], rx_cfg_i[31:24]};

   always_comb begin
      state_nxt = state;
      // In IDLE the live div is used so a phase-0 first sample lands in the right chip slot.
      div_eff   = (state == ST_IDLE) ? cfg_div : div_q;
      in_chip   = (state == ST_SEED) || (state == ST_CHECK) || (skip_cnt >= cfg_phase);
      take      = cfg_en && s_axis_tvalid && in_chip;
      skip      = cfg_en && s_axis_tvalid && !in_chip;
      chip_last = (samp_cnt == div_eff);
      dec_bit   = !acc[ACC_WIDTH-1] && (acc != '0);
      seeding   = chip_end_q && (state == ST_SEED);
      checking  = chip_end_q && (state == ST_CHECK);
      err       = checking && (dec_bit != exp_bit);
      win_errs  = win_err + {6'd0, err};
      win_end   = checking && (win_cnt == 6'(WIN_LEN-1));
      lock_lost = win_end && (win_errs >= 7'(ERR_THRESH));
      lock_nxt  = win_end ? !lock_lost : rx_lock_o;
      seed_last = seeding && (seed_cnt == ({1'b0, order_q} + 4'd2));

      rec                  = '0;
      rec[ACC_WIDTH-1:0]   = acc;
      rec[REC_BIT_POS]     = dec_bit;
      rec[REC_ERR_POS]     = err;
      rec[REC_LOCK_POS]    = lock_nxt;

      case (state)
         ST_IDLE:  if (take) state_nxt = ST_SEED; else if (skip) state_nxt = ST_SKIP;
         ST_SKIP:  if (take) state_nxt = ST_SEED;
         ST_SEED:  if (seed_last) state_nxt = ST_CHECK;
         ST_CHECK: if (lock_lost) state_nxt = ST_SEED;
         default:  state_nxt = ST_IDLE;
      endcase
      if (!cfg_en) state_nxt = ST_IDLE;
   end

   always_ff @(posedge aclk) begin
      if (srst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         div_q         <= '0;
         order_q       <= '0;
         skip_cnt      <= '0;
         samp_cnt      <= '0;
         acc           <= '0;
         chip_end_q    <= 1'b0;
         seed_cnt      <= '0;
         win_cnt       <= '0;
         win_err       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         rx_lock_o     <= 1'b0;
         rx_err_cnt_o  <= '0;
         rx_chip_cnt_o <= '0;
         rx_ovf_o      <= 1'b0;
      end else begin
         if (state == ST_IDLE) begin
            div_q   <= cfg_div;
            order_q <= cfg_order;
         end
         if (!cfg_en) begin
            skip_cnt      <= '0;
            samp_cnt      <= '0;
            acc           <= '0;
            chip_end_q    <= 1'b0;
            seed_cnt      <= '0;
            win_cnt       <= '0;
            win_err       <= '0;
            m_axis_tvalid <= 1'b0;
            rx_lock_o     <= 1'b0;
         end else begin
            chip_end_q <= take && chip_last;
            if (skip) skip_cnt <= skip_cnt + 8'd1;
            if (take) begin
               samp_cnt <= chip_last ? 8'd0 : samp_cnt + 8'd1;
`ifdef PRBS_RX_INTEGRATE_EN
               acc <= (samp_cnt == 8'd0) ? sample_ext : acc + sample_ext;
`else
               if (samp_cnt == (div_eff >> 1)) acc <= sample_ext;
`endif
            end
            m_axis_tvalid <= chip_end_q;
            if (chip_end_q) m_axis_tdata <= rec;
            if (seeding) seed_cnt <= seed_last ? 4'd0 : seed_cnt + 4'd1;
            if (checking) begin
               win_cnt   <= win_cnt + 6'd1;
               win_err   <= win_end ? 7'd0 : win_errs;
               rx_lock_o <= lock_nxt;
            end
         end
         // clr outranks any increment landing in the same cycle
         if (cfg_clr) begin
            rx_err_cnt_o  <= '0;
            rx_chip_cnt_o <= '0;
            rx_ovf_o      <= 1'b0;
         end else begin
            if (checking && (rx_chip_cnt_o != '1)) rx_chip_cnt_o <= rx_chip_cnt_o + 32'd1;
            if (err && (rx_err_cnt_o != '1))       rx_err_cnt_o  <= rx_err_cnt_o + 32'd1;
            if (m_axis_tvalid && !m_axis_tready)   rx_ovf_o      <= 1'b1;
         end
      end
   end

   prbs_rx_lfsr u_lfsr (
      .aclk     (aclk),
      .srst     (srst),
      .clr      (!cfg_en),
      .shift    (seeding || checking),
      .din      (dec_bit),
      .tap_mask (tap_mask(order_q)),
      .exp_bit  (exp_bit)
   );

endmodule

// File: tb/tb_axis_red_pitaya_prbs_rx.sv
// Scoreboard bench for axis_red_pitaya_prbs_rx: a sample-level reference model predicts each record,
// a negedge monitor pops and compares whenever m_axis_tvalid is seen.
module tb_axis_red_pitaya_prbs_rx;

   logic        aclk = 1'b0;
   logic        srst;
   logic        s_axis_tready;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic [31:0] rx_cfg_i;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        rx_lock_o;
   logic [31:0] rx_err_cnt_o;
   logic [31:0] rx_chip_cnt_o;
   logic        rx_ovf_o;

   axis_red_pitaya_prbs_rx #(.ADC_DATA_WIDTH(14), .AXIS_TDATA_WIDTH(32), .ACC_WIDTH(24)) dut (
      .aclk          (aclk),
      .srst          (srst),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .rx_cfg_i      (rx_cfg_i),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .rx_lock_o     (rx_lock_o),
      .rx_err_cnt_o  (rx_err_cnt_o),
      .rx_chip_cnt_o (rx_chip_cnt_o),
      .rx_ovf_o      (rx_ovf_o)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          cyc;
      logic [31:0] tdata;
      logic        lock;
      int          errc;
      int          chipc;
   } exp_t;

   exp_t exp_q[$];
   // polynomial exponents (0 = unused slot); bit n = XOR of bit n-k over listed k
   int   poly [8][4] = '{'{3,2,0,0}, '{4,3,0,0}, '{5,3,0,0}, '{6,5,0,0},
                         '{7,6,0,0}, '{8,6,5,4}, '{9,5,0,0}, '{10,7,0,0}};
   int   m_div, m_order, skip_left, seed_left, win_n, win_e;
   int   m_errc = 0;
   int   m_chipc = 0;
   bit   m_lock = 0;
   bit   model_on = 0;
   int   samp_vals[$];
   bit   hist[$];

   task automatic model_start(input int div, input int order, input int phase);
      m_div = div; m_order = order; skip_left = phase;
      seed_left = order + 3; win_n = 0; win_e = 0; m_lock = 0;
      samp_vals.delete(); hist.delete();
   endtask

   task automatic model_chip(input int value, input int c);
      bit          b, e, x;
      logic [31:0] vv, r;
      exp_t        ex;
      b = (value > 0);
      e = 0;
      if (seed_left > 0) begin
         hist.push_back(b);
         seed_left--;
      end else begin
         x = 0;
         for (int t = 0; t < 4; t++)
            if (poly[m_order][t] != 0) x ^= hist[hist.size() - poly[m_order][t]];
         e = (b != x);
         hist.push_back(b);
         m_chipc++;
         if (e) m_errc++;
         win_n++;
         win_e += int'(e);
         if (win_n == 64) begin
            if (win_e >= 8) begin
               m_lock = 0;
               seed_left = m_order + 3;
            end else begin
               m_lock = 1;
            end
            win_n = 0;
            win_e = 0;
         end
      end
      if (hist.size() > 16) void'(hist.pop_front());
      vv = value;
      r = '0;
      r[23:0] = vv[23:0];
      r[24] = b;
      r[25] = e;
      r[26] = m_lock;
      ex.cyc = c + 2; ex.tdata = r; ex.lock = m_lock; ex.errc = m_errc; ex.chipc = m_chipc;
      exp_q.push_back(ex);
   endtask

   task automatic model_sample(input int v, input int c);
      int value;
      if (skip_left > 0) begin
         skip_left--;
         return;
      end
      samp_vals.push_back(v);
      if (samp_vals.size() == m_div + 1) begin
`ifdef PRBS_RX_INTEGRATE_EN
         value = 0;
         foreach (samp_vals[i]) value += samp_vals[i];
`else
         value = samp_vals[m_div / 2];
`endif
         samp_vals.delete();
         model_chip(value, c);
      end
   endtask

   // ---------------- monitor ----------------
   logic [31:0] last_tdata = '0;

   always @(negedge aclk) begin
      exp_t ex;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         check("rec_missing", cyc, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (m_axis_tvalid === 1'b1) begin
         last_tdata = m_axis_tdata;
         if (exp_q.size() == 0) begin
            check("rec_spurious", m_axis_tvalid, 0);
         end else begin
            ex = exp_q.pop_front();
            check("rec_cycle", cyc, ex.cyc);
            check("rec_tdata", m_axis_tdata, ex.tdata);
            check("rec_lock", rx_lock_o, ex.lock);
            check("rec_err_cnt", rx_err_cnt_o, ex.errc);
            check("rec_chip_cnt", rx_chip_cnt_o, ex.chipc);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic drive(input int v, input bit vld);
      logic [31:0] vv;
      logic [15:0] junk;
      @(posedge aclk);
      #1;
      vv = v;
      junk = 16'($urandom);
      s_axis_tdata  = {junk, {2{vv[13]}}, vv[13:0]};
      s_axis_tvalid = vld;
      if (vld && model_on) model_sample(v, cyc);
   endtask

   task automatic drain(input int n);
      repeat (n) drive(int'($urandom_range(0, 16383)) - 8192, 1'b0);
   endtask

   task automatic gaps(input int pct);
      for (int g = 0; g < 8 && int'($urandom_range(0, 99)) < pct; g++) drain(1);
   endtask

   task automatic set_cfg(input int div, input int order, input int phase, input bit en, input bit clr);
      logic [31:0] w, d, o, p;
      w = $urandom;
      d = div; o = order; p = phase;
      w[7:0] = d[7:0];
      w[13:11] = o[2:0];
      w[14] = en;
      w[15] = clr;
      w[23:16] = p[7:0];
      rx_cfg_i = w;
   endtask

   task automatic start(input int div, input int order, input int phase);
      model_on = 0;
      drain(4);
      set_cfg(div, order, phase, 1'b0, 1'b0);
      drain(1);
      check("en_off_lock", rx_lock_o, m_lock & 1'b0);
      check("en_off_tvalid", m_axis_tvalid, 0);
      drain(1);
      set_cfg(div, order, phase, 1'b1, 1'b0);
      model_start(div, order, phase);
      model_on = 1;
   endtask

   task automatic send_prbs_chip(input bit b, input int gap);
      for (int s = 0; s <= m_div; s++) begin
         gaps(gap);
         drive((b ? 4000 : -4000) + int'($urandom_range(0, 200)) - 100, 1'b1);
      end
   endtask

   task automatic send_rand_chip(input int gap);
      int v;
      for (int s = 0; s <= m_div; s++) begin
         gaps(gap);
         v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 16383)) - 8192;
         drive(v, 1'b1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tvalid"}, m_axis_tvalid, 0);
      check({tag, "_tdata"}, m_axis_tdata, 0);
      check({tag, "_lock"}, rx_lock_o, 0);
      check({tag, "_err_cnt"}, rx_err_cnt_o, 0);
      check({tag, "_chip_cnt"}, rx_chip_cnt_o, 0);
      check({tag, "_ovf"}, rx_ovf_o, 0);
      check({tag, "_tready"}, s_axis_tready, 1);
   endtask

   // ---------------- stimulus ----------------
   bit prbs[$];

   initial begin
      srst = 1'b1;
      rx_cfg_i = '0;
      s_axis_tdata = '0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check_all_zero("reset");
      srst = 1'b0;

      // PRBS3, div 3, one chip inverted at checked chip 100
      prbs = '{1'b1, 1'b0, 1'b0};
      for (int n = 3; n < 220; n++) prbs.push_back(prbs[n-3] ^ prbs[n-2]);
      start(3, 0, 0);
      for (int i = 0; i < 203; i++) send_prbs_chip((i == 103) ? !prbs[i] : prbs[i], 30);
      drain(5);
      check("prbs_lock", rx_lock_o, m_lock);
      check("prbs_err_cnt", rx_err_cnt_o, m_errc);
      check("prbs_chip_cnt", rx_chip_cnt_o, m_chipc);

      // overflow: one record refused by the sink
      m_axis_tready = 1'b0;
      send_prbs_chip(prbs[203], 0);
      drain(4);
      m_axis_tready = 1'b1;
      check("ovf_set", rx_ovf_o, 1);
      for (int i = 204; i < 208; i++) send_prbs_chip(prbs[i], 20);
      drain(4);
      check("ovf_sticky", rx_ovf_o, 1);
      set_cfg(3, 0, 0, 1'b1, 1'b1);
      drain(1);
      m_errc = 0;
      m_chipc = 0;
      check("clr_err_cnt", rx_err_cnt_o, m_errc);
      check("clr_chip_cnt", rx_chip_cnt_o, m_chipc);
      check("clr_ovf", rx_ovf_o, 0);
      check("clr_keeps_lock", rx_lock_o, m_lock);
      set_cfg(3, 0, 0, 1'b1, 1'b0);

      // order 7 fed random bits: never locks, keeps reseeding
      start(1, 7, 0);
      for (int i = 0; i < 220; i++) send_prbs_chip(1'($urandom), 20);
      drain(5);
      check("rand_lock", rx_lock_o, m_lock);
      check("rand_err_cnt", rx_err_cnt_o, m_errc);

      // full-scale chip, div 255
      start(255, 3, 0);
      for (int s = 0; s < 256; s++) drive(8191, 1'b1);
      drain(5);
`ifdef PRBS_RX_INTEGRATE_EN
      check("fullscale_value", last_tdata[24:0], 25'h11FFF00);
`else
      check("fullscale_value", last_tdata[24:0], 25'h1001FFF);
`endif
      for (int s = 0; s < 256; s++) drive(-8192, 1'b1);
      drain(5);

      // phase 5, 50% valid, random sample values including zeros
      start(6, 2, 5);
      for (int i = 0; i < 60; i++) send_rand_chip(50);
      drain(5);
      start(0, 1, 2);
      for (int i = 0; i < 40; i++) send_rand_chip(30);
      drain(5);
      check("randval_chip_cnt", rx_chip_cnt_o, m_chipc);

      // srst in the middle of a chip
      start(7, 0, 0);
      for (int s = 0; s < 3; s++) drive(3000, 1'b1);
      srst = 1'b1;
      model_on = 0;
      drain(1);
      exp_q.delete();
      m_errc = 0;
      m_chipc = 0;
      check_all_zero("srst_mid");
      srst = 1'b0;
      drain(12);
      set_cfg(0, 0, 0, 1'b0, 1'b0);
      drain(3);

      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
